// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream receive endpoint.
// The beat struct is the FIFO word; rx_state_e tracks frame boundaries.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_USER_W = 2;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] tstrb;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic [AXIS_USER_W-1:0] user;
        logic                   last;
    } axis_beat_t;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_FRAME = 1'b1
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
    endfunction

endpackage

// File: rtl/axis_slave_rx_if.sv
// Upstream AXI-Stream bus into the receive endpoint.
// The master drives the beat; the slave (this block) answers with tready.
interface axis_slave_rx_if;
    import axis_pkg::*;

    logic                   axis_tvalid;
    logic [AXIS_DATA_W-1:0] axis_tdata;
    logic [AXIS_KEEP_W-1:0] axis_tstrb;
    logic [AXIS_KEEP_W-1:0] axis_tkeep;
    logic                   axis_tlast;
    logic [AXIS_USER_W-1:0] axis_tuser;
    logic                   axis_tready;

    modport master (
        output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
        input  axis_tready
    );

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
        output axis_tready
    );

endinterface

// File: rtl/axis_rx_fifo.sv
// First-word-fall-through FIFO of stream beats. The head entry is visible
// combinationally; pointers carry an extra wrap bit to separate full from empty.
module axis_rx_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  axis_beat_t wr_beat,
    input  logic       pop,
    output axis_beat_t head,
    output logic       full,
    output logic       empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    axis_beat_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                   (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    assign head = mem_r[rd_ptr_r[ADDR_W-1:0]];

    // Pointer advance; the low bits wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_beat;
        end
    end

endmodule

// File: rtl/axis_slave_rx.sv
// AXI-Stream receive endpoint: buffers upstream beats for a valid/ready backend
// and reports frame lengths and backend stall status.
module axis_slave_rx
    import axis_pkg::*;
#(
    parameter int         DEPTH         = 8,
    parameter logic [7:0] STALL_TIMEOUT = 8'd5
) (
    input  logic                   axi_aclk,
    input  logic                   axi_areset,
    axis_slave_rx_if.slave         rx_bus,
    output logic                   bk_valid,
    output logic [AXIS_DATA_W-1:0] bk_data,
    output logic [AXIS_KEEP_W-1:0] bk_tstrb,
    output logic [AXIS_KEEP_W-1:0] bk_tkeep,
    output logic [AXIS_USER_W-1:0] bk_user,
    output logic                   bk_last,
    input  logic                   bk_ready,
    output logic                   bk_frame_done,
    output logic [15:0]            bk_frame_len,
    output logic                   bk_stall
);

    axis_beat_t  in_beat_s;
    axis_beat_t  head_s;
    axis_beat_t  head_vis_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        tready_s;
    logic        accept_s;
    logic        null_beat_s;
    logic        push_s;
    logic        pop_s;
    logic [7:0]  stall_cnt_nxt_s;

    rx_state_e   state_r;
    logic [15:0] beat_cnt_r;
    logic [15:0] frame_len_r;
    logic        frame_done_r;
    logic [7:0]  stall_cnt_r;
    logic        stall_r;

    assign in_beat_s.data  = rx_bus.axis_tdata;
    assign in_beat_s.tstrb = rx_bus.axis_tstrb;
    assign in_beat_s.tkeep = rx_bus.axis_tkeep;
    assign in_beat_s.user  = rx_bus.axis_tuser;
    assign in_beat_s.last  = rx_bus.axis_tlast;

    // Ready depends only on FIFO space, never on the backend.
    assign tready_s           = ~fifo_full_s & ~axi_areset;
    assign rx_bus.axis_tready = tready_s;
    assign accept_s           = rx_bus.axis_tvalid & tready_s;

    // Empty beats are counted but dropped, unless they carry the frame boundary.
    assign null_beat_s = (rx_bus.axis_tkeep == {AXIS_KEEP_W{1'b0}}) & ~rx_bus.axis_tlast;
    assign push_s      = accept_s & ~null_beat_s;
    assign pop_s       = bk_valid & bk_ready;

    axis_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .push    (push_s),
        .wr_beat (in_beat_s),
        .pop     (pop_s),
        .head    (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Backend sees zeros whenever nothing is buffered.
    always_comb begin
        head_vis_s = {$bits(axis_beat_t){1'b0}};
        if (!fifo_empty_s) begin
            head_vis_s = head_s;
        end else begin
            head_vis_s = {$bits(axis_beat_t){1'b0}};
        end
    end

    assign bk_valid = ~fifo_empty_s;
    assign bk_data  = head_vis_s.data;
    assign bk_tstrb = head_vis_s.tstrb;
    assign bk_tkeep = head_vis_s.tkeep;
    assign bk_user  = head_vis_s.user;
    assign bk_last  = head_vis_s.last;

    // Frame FSM with beat counter and completed-frame reporting.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_r      <= RX_IDLE;
            beat_cnt_r   <= 16'h0000;
            frame_len_r  <= 16'h0000;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (accept_s) begin
                if (rx_bus.axis_tlast) begin
                    frame_len_r  <= sat_inc16(beat_cnt_r);
                    beat_cnt_r   <= 16'h0000;
                    frame_done_r <= 1'b1;
                end else begin
                    beat_cnt_r <= sat_inc16(beat_cnt_r);
                end
            end
            case (state_r)
                RX_IDLE: begin
                    if (accept_s && !rx_bus.axis_tlast) begin
                        state_r <= RX_FRAME;
                    end
                end
                RX_FRAME: begin
                    if (accept_s && rx_bus.axis_tlast) begin
                        state_r <= RX_IDLE;
                    end
                end
                default: state_r <= RX_IDLE;
            endcase
        end
    end

    // Stall counter only runs while a head is waiting and not taken.
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        if (fifo_empty_s || pop_s) begin
            stall_cnt_nxt_s = 8'h00;
        end else begin
            stall_cnt_nxt_s = sat_inc8(stall_cnt_r);
        end
    end

    // Stall flag registered from the next count so it tracks the counter exactly.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            stall_cnt_r <= 8'h00;
            stall_r     <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_nxt_s;
            stall_r     <= (stall_cnt_nxt_s >= STALL_TIMEOUT);
        end
    end

    assign bk_frame_done = frame_done_r;
    assign bk_frame_len  = frame_len_r;
    assign bk_stall      = stall_r;

endmodule

// File: tb/tb_axis_slave_rx.sv
// Directed bench for axis_slave_rx: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_axis_slave_rx;

    logic        clk;
    logic        rst;
    logic        bk_valid;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_last;
    logic        bk_ready;
    logic        bk_frame_done;
    logic [15:0] bk_frame_len;
    logic        bk_stall;

    int tests  = 0;
    int failed = 0;

    logic [31:0] tx_data [64];
    logic [3:0]  tx_keep [64];
    bit          tx_last [64];
    logic [31:0] rx_data [$];
    bit          rx_last [$];
    logic [15:0] done_lens [$];
    int          bubbles;

    axis_slave_rx_if bus ();

    axis_slave_rx #(
        .DEPTH         (8),
        .STALL_TIMEOUT (8'd5)
    ) dut (
        .axi_aclk      (clk),
        .axi_areset    (rst),
        .rx_bus        (bus.slave),
        .bk_valid      (bk_valid),
        .bk_data       (bk_data),
        .bk_tstrb      (bk_tstrb),
        .bk_tkeep      (bk_tkeep),
        .bk_user       (bk_user),
        .bk_last       (bk_last),
        .bk_ready      (bk_ready),
        .bk_frame_done (bk_frame_done),
        .bk_frame_len  (bk_frame_len),
        .bk_stall      (bk_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_beat(input bit v, input logic [31:0] d, input logic [3:0] keep, input bit last);
        bus.axis_tvalid = v;
        bus.axis_tdata  = d;
        bus.axis_tstrb  = keep;
        bus.axis_tkeep  = keep;
        bus.axis_tlast  = last;
        bus.axis_tuser  = d[1:0];
    endtask

    // Streams tx_* beats with the current bk_ready and records what the backend takes.
    task automatic run_stream(input int n, input int budget, output bit timed_out);
        int sent = 0;
        int cyc  = 0;
        bit seen = 0;
        bit fin  = 0;
        bit acc;
        rx_data.delete();
        rx_last.delete();
        done_lens.delete();
        bubbles = 0;
        while (!fin && cyc < budget) begin
            if (sent < n) drive_beat(1'b1, tx_data[sent], tx_keep[sent], tx_last[sent]);
            else drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
            @(negedge clk);
            if (bk_frame_done) done_lens.push_back(bk_frame_len);
            if (bk_valid) begin
                seen = 1;
                if (bk_ready) begin
                    rx_data.push_back(bk_data);
                    rx_last.push_back(bk_last);
                end
            end else if (seen && sent < n) begin
                bubbles++;
            end
            acc = bus.axis_tvalid && bus.axis_tready;
            if (sent == n && !bk_valid) fin = 1;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bk_ready = 1'b0;
        drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.axis_tready !== 1'b0) begin failed++; $display("FAIL reset_tready got %b exp 0", bus.axis_tready); end
        tests++; if (bk_valid !== 1'b0) begin failed++; $display("FAIL reset_bk_valid got %b exp 0", bk_valid); end
        tests++; if (bk_frame_len !== 16'h0) begin failed++; $display("FAIL reset_frame_len got %h exp 0", bk_frame_len); end
        tests++; if (bk_stall !== 1'b0 || bk_frame_done !== 1'b0) begin failed++; $display("FAIL reset_flags got stall=%b done=%b exp 0/0", bk_stall, bk_frame_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.axis_tready !== 1'b1) begin failed++; $display("FAIL release_tready got %b exp 1", bus.axis_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        bk_ready = 1'b1;
        drive_beat(1'b1, 32'hA5A5_0001, 4'hF, 1'b1);
        @(negedge clk);
        tests++; if (bk_valid !== 1'b0) begin failed++; $display("FAIL single_pre_valid got %b exp 0", bk_valid); end
        @(posedge clk); #1;
        drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        tests++; if (bk_valid !== 1'b1 || bk_data !== 32'hA5A5_0001) begin failed++; $display("FAIL single_data got v=%b d=%h exp 1/a5a50001", bk_valid, bk_data); end
        tests++; if (bk_last !== 1'b1 || bk_tkeep !== 4'hF || bk_user !== 2'b01) begin failed++; $display("FAIL single_side got last=%b keep=%h user=%b exp 1/f/01", bk_last, bk_tkeep, bk_user); end
        tests++; if (bk_frame_done !== 1'b1 || bk_frame_len !== 16'd1) begin failed++; $display("FAIL single_done got done=%b len=%0d exp 1/1", bk_frame_done, bk_frame_len); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (bk_frame_done !== 1'b0 || bk_frame_len !== 16'd1) begin failed++; $display("FAIL single_after got done=%b len=%0d exp 0/1", bk_frame_done, bk_frame_len); end
        tests++; if (bk_valid !== 1'b0 || bk_data !== 32'h0 || bk_last !== 1'b0) begin failed++; $display("FAIL single_empty got v=%b d=%h last=%b exp 0/0/0", bk_valid, bk_data, bk_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int valid_cyc = -1;
        int stall_cyc = -1;
        int full_at = -1;
        int k = 0;
        int bad = 0;
        bit acc;
        bk_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            drive_beat(sent < 10, 32'h1000_0000 + sent, 4'hF, sent == 9);
            @(negedge clk);
            if (bk_valid && valid_cyc < 0) valid_cyc = c;
            if (bk_stall && stall_cyc < 0) stall_cyc = c;
            if (!bus.axis_tready && full_at < 0) full_at = sent;
            acc = bus.axis_tvalid && bus.axis_tready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        tests++; if (full_at !== 8 || sent !== 8) begin failed++; $display("FAIL bp_full got accepts_at_full=%0d total=%0d exp 8/8", full_at, sent); end
        tests++; if (valid_cyc < 0 || stall_cyc - valid_cyc !== 5) begin failed++; $display("FAIL bp_stall_delay got valid@%0d stall@%0d exp distance 5", valid_cyc, stall_cyc); end
        bk_ready = 1'b1;
        while (got < 10 && k < 30) begin
            drive_beat(sent < 10, 32'h1000_0000 + sent, 4'hF, sent == 9);
            @(negedge clk);
            if (k == 0) begin
                tests++; if (bus.axis_tready !== 1'b0) begin failed++; $display("FAIL bp_still_full got %b exp 0", bus.axis_tready); end
            end
            if (k == 1) begin
                tests++; if (bus.axis_tready !== 1'b1) begin failed++; $display("FAIL bp_ready_rise got %b exp 1", bus.axis_tready); end
            end
            if (bk_valid && bk_ready) begin
                if (bk_data !== 32'h1000_0000 + got || bk_last !== (got == 9)) bad++;
                got++;
            end
            acc = bus.axis_tvalid && bus.axis_tready;
            @(posedge clk); #1;
            if (acc) sent++;
            k++;
        end
        drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        tests++; if (got !== 10 || bad !== 0) begin failed++; $display("FAIL bp_order got received=%0d wrong=%0d exp 10/0", got, bad); end
        tests++; if (bk_stall !== 1'b0) begin failed++; $display("FAIL bp_stall_clear got %b exp 0", bk_stall); end
        tests++; if (bk_frame_len !== 16'd10) begin failed++; $display("FAIL bp_frame_len got %0d exp 10", bk_frame_len); end
        @(posedge clk); #1;
    endtask

    task automatic test_null_beat();
        bit to;
        bk_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data[i] = 32'h2000_0000 + i;
            tx_keep[i] = (i == 1) ? 4'h0 : 4'hF;
            tx_last[i] = (i == 3);
        end
        run_stream(4, 30, to);
        tests++; if (to || rx_data.size() !== 3) begin failed++; $display("FAIL null_count got timeout=%0d beats=%0d exp 0/3", to, rx_data.size()); end
        else begin
            tests++; if (rx_data[0] !== 32'h2000_0000 || rx_data[1] !== 32'h2000_0002 || rx_data[2] !== 32'h2000_0003 || rx_last[2] !== 1'b1)
                begin failed++; $display("FAIL null_data got %h %h %h last=%b exp 20000000 20000002 20000003 1", rx_data[0], rx_data[1], rx_data[2], rx_last[2]); end
        end
        tests++; if (done_lens.size() !== 1 || done_lens[0] !== 16'd4) begin failed++; $display("FAIL null_len got pulses=%0d len=%0d exp 1/4", done_lens.size(), (done_lens.size() > 0) ? done_lens[0] : 16'hFFFF); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int bad = 0;
        bk_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tx_data[i] = 32'h3000_0000 + i;
            tx_keep[i] = 4'hF;
            tx_last[i] = ((i % 16) == 15);
        end
        run_stream(40, 80, to);
        tests++; if (to || rx_data.size() !== 40) begin failed++; $display("FAIL b2b_count got timeout=%0d beats=%0d exp 0/40", to, rx_data.size()); end
        else begin
            for (int i = 0; i < 40; i++) if (rx_data[i] !== 32'h3000_0000 + i || rx_last[i] !== ((i % 16) == 15)) bad++;
            tests++; if (bad !== 0) begin failed++; $display("FAIL b2b_order got wrong=%0d exp 0", bad); end
        end
        tests++; if (bubbles !== 0) begin failed++; $display("FAIL b2b_bubbles got %0d exp 0", bubbles); end
        tests++; if (done_lens.size() !== 2 || done_lens[0] !== 16'd16 || done_lens[1] !== 16'd16)
            begin failed++; $display("FAIL b2b_lens got pulses=%0d exp 2 frames of 16", done_lens.size()); end
    endtask

    task automatic test_reset_midframe();
        int pulses = 0;
        bit to;
        bk_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_beat(1'b1, 32'h5000_0000 + c, 4'hF, 1'b0);
            @(negedge clk);
            if (bk_frame_done) pulses++;
            @(posedge clk); #1;
        end
        drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        if (bk_frame_done) pulses++;
        tests++; if (bk_valid !== 1'b0 || bus.axis_tready !== 1'b0) begin failed++; $display("FAIL mid_reset got valid=%b tready=%b exp 0/0", bk_valid, bus.axis_tready); end
        tests++; if (bk_frame_len !== 16'h0) begin failed++; $display("FAIL mid_reset_len got %0d exp 0", bk_frame_len); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        if (bk_frame_done) pulses++;
        tests++; if (bk_valid !== 1'b0 || bus.axis_tready !== 1'b1) begin failed++; $display("FAIL mid_release got valid=%b tready=%b exp 0/1", bk_valid, bus.axis_tready); end
        @(posedge clk); #1;
        bk_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tx_data[i] = 32'h4000_0000 + i;
            tx_keep[i] = 4'hF;
            tx_last[i] = (i == 1);
        end
        run_stream(2, 20, to);
        tests++; if (pulses !== 0) begin failed++; $display("FAIL mid_no_done got %0d pulses exp 0", pulses); end
        tests++; if (to || rx_data.size() !== 2 || rx_data[0] !== 32'h4000_0000) begin failed++; $display("FAIL mid_next_frame got timeout=%0d beats=%0d exp 0/2", to, rx_data.size()); end
        tests++; if (done_lens.size() !== 1 || done_lens[0] !== 16'd2) begin failed++; $display("FAIL mid_len got pulses=%0d len=%0d exp 1/2", done_lens.size(), (done_lens.size() > 0) ? done_lens[0] : 16'hFFFF); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_null_beat();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
